foreign_byte_queue: RTL and testbench

- Instruction-byte aligner directly upstream of the foreign (x86) prefix/opcode/modrm decoder.
- Accepts 16-byte fetch packets, buffers them in a byte ring, and presents a 16-byte window starting at the current instruction start: win_lo = bytes 0-7 (decoder A), win_hi = bytes 8-15 (decoder B).
- The decoder returns the decoded instruction length, and the queue advances by that many bytes.

---
 rtl/foreign_pkg.sv | 10 +
 rtl/foreign_byte_rotator.sv | 27 ++
 rtl/foreign_byte_queue.sv | 121 ++++++++++++
 tb/tb_foreign_byte_queue.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/foreign_pkg.sv
// Shared constants and types for the foreign (x86) instruction byte queue.
package foreign_pkg;

    localparam int FETCH_BYTES  = 16;
    localparam int WIN_BYTES    = 16;
    localparam int MAX_INSN_LEN = 15;

    typedef logic [WIN_BYTES-1:0][7:0] foreign_win_t;

endpackage

// File: rtl/foreign_byte_rotator.sv
// Combinational window extractor: 16 ring bytes from the read pointer, zero past occupancy.
module foreign_byte_rotator
    import foreign_pkg::*;
#(
    parameter  int DEPTH_BYTES = 64,
    localparam int AW          = $clog2(DEPTH_BYTES),
    localparam int OW          = AW + 1
) (
    input  logic [DEPTH_BYTES-1:0][7:0] i_ring,
    input  logic [AW-1:0]               i_rd_base,
    input  logic [OW-1:0]               i_occ,
    output foreign_win_t                o_win
);

    // Index arithmetic is AW bits wide, so windows crossing the ring end wrap for free.
    always_comb begin
        o_win = '0;
        for (int k = 0; k < WIN_BYTES; k++) begin
            if (OW'(k) < i_occ) begin
                o_win[k] = i_ring[i_rd_base + AW'(k)];
            end else begin
                o_win[k] = 8'h00;
            end
        end
    end

endmodule

// File: rtl/foreign_byte_queue.sv
// Byte ring between fetch and the foreign decoder; presents a 16-byte window at the
// current instruction start and advances by the decoded length.
module foreign_byte_queue
    import foreign_pkg::*;
#(
    parameter int DEPTH_BYTES = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          fetch_vld,
    input  logic [127:0]                  fetch_data,
    input  logic [3:0]                    fetch_skip,
    output logic                          fetch_rdy,
    output logic [63:0]                   win_lo,
    output logic [63:0]                   win_hi,
    output logic [$clog2(DEPTH_BYTES):0]  win_cnt,
    output logic                          win_vld,
    input  logic                          cons_en,
    input  logic [3:0]                    cons_len,
    output logic                          cons_err
);

    localparam int SLOTS = DEPTH_BYTES / FETCH_BYTES;
    localparam int SW    = $clog2(SLOTS);
    localparam int WW    = SW + 1;
    localparam int AW    = $clog2(DEPTH_BYTES);
    localparam int RW    = AW + 1;

    logic [DEPTH_BYTES-1:0][7:0] r_ring;
    logic [WW-1:0]               r_wptr;
    logic [RW-1:0]               r_rptr;
    logic                        r_first_pending;
    logic                        r_cons_err;

    logic [WW-1:0]               w_wptr_nxt;
    logic [RW-1:0]               w_rptr_nxt;
    logic                        w_first_nxt;
    logic [RW-1:0]               w_wbyte;
    logic [RW-1:0]               w_occ;
    logic                        w_accept;
    logic                        w_cons_req;
    logic                        w_cons_ok;
    logic                        w_cons_bad;
    foreign_win_t                w_win;

    // Wrap bits on both pointers make full (occ == DEPTH) distinct from empty.
    assign w_wbyte    = {r_wptr, 4'b0000};
    assign w_occ      = w_wbyte - r_rptr;
    assign fetch_rdy  = (w_occ <= RW'(DEPTH_BYTES - FETCH_BYTES));
    assign w_accept   = fetch_vld & fetch_rdy & ~flush;
    assign w_cons_req = cons_en & ~flush & (cons_len != 4'd0);
    assign w_cons_ok  = w_cons_req & (RW'(cons_len) <= w_occ);
    assign w_cons_bad = w_cons_req & ~w_cons_ok;

    // Pointer and first-packet bookkeeping for the next cycle.
    always_comb begin
        w_wptr_nxt  = r_wptr;
        w_rptr_nxt  = r_rptr;
        w_first_nxt = r_first_pending;
        if (flush) begin
            w_rptr_nxt  = w_wbyte;
            w_first_nxt = 1'b1;
        end else begin
            if (w_accept) begin
                w_wptr_nxt = r_wptr + WW'(1);
            end else begin
                w_wptr_nxt = r_wptr;
            end
            // occ is 0 while first_pending, so a same-cycle consume is always illegal here.
            if (w_accept && r_first_pending) begin
                w_rptr_nxt  = w_wbyte + RW'(fetch_skip);
                w_first_nxt = 1'b0;
            end else if (w_cons_ok) begin
                w_rptr_nxt = r_rptr + RW'(cons_len);
            end else begin
                w_rptr_nxt = r_rptr;
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr          <= '0;
            r_rptr          <= '0;
            r_first_pending <= 1'b1;
            r_cons_err      <= 1'b0;
        end else begin
            r_wptr          <= w_wptr_nxt;
            r_rptr          <= w_rptr_nxt;
            r_first_pending <= w_first_nxt;
            r_cons_err      <= w_cons_bad;
        end
    end

    // Ring storage; contents survive flush and are hidden by occupancy masking.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int k = 0; k < FETCH_BYTES; k++) begin
                r_ring[{r_wptr[SW-1:0], 4'(k)}] <= fetch_data[8*k +: 8];
            end
        end
    end

    foreign_byte_rotator #(
        .DEPTH_BYTES (DEPTH_BYTES)
    ) u_rotator (
        .i_ring    (r_ring),
        .i_rd_base (r_rptr[AW-1:0]),
        .i_occ     (w_occ),
        .o_win     (w_win)
    );

    assign win_lo   = w_win[7:0];
    assign win_hi   = w_win[15:8];
    assign win_cnt  = w_occ;
    assign win_vld  = (w_occ >= RW'(WIN_BYTES));
    assign cons_err = r_cons_err;

endmodule

// File: tb/tb_foreign_byte_queue.sv
// Directed self-checking bench for foreign_byte_queue (DEPTH_BYTES = 64).
module tb_foreign_byte_queue;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         fetch_vld;
    logic [127:0] fetch_data;
    logic [3:0]   fetch_skip;
    logic         fetch_rdy;
    logic [63:0]  win_lo;
    logic [63:0]  win_hi;
    logic [6:0]   win_cnt;
    logic         win_vld;
    logic         cons_en;
    logic [3:0]   cons_len;
    logic         cons_err;

    int n_checks = 0;
    int n_errors = 0;

    foreign_byte_queue #(.DEPTH_BYTES(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .fetch_vld  (fetch_vld),
        .fetch_data (fetch_data),
        .fetch_skip (fetch_skip),
        .fetch_rdy  (fetch_rdy),
        .win_lo     (win_lo),
        .win_hi     (win_hi),
        .win_cnt    (win_cnt),
        .win_vld    (win_vld),
        .cons_en    (cons_en),
        .cons_len   (cons_len),
        .cons_err   (cons_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] mkpkt(input int base);
        logic [127:0] d;
        for (int k = 0; k < 16; k++) d[8*k +: 8] = 8'(base + k);
        return d;
    endfunction

    // Stream bytes carry their own sequence number, so the window is h..h+15 masked by n.
    function automatic logic [127:0] exp_win(input int h, input int n);
        logic [127:0] w;
        w = '0;
        for (int k = 0; k < 16; k++) begin
            if (k < n) w[8*k +: 8] = 8'(h + k);
        end
        return w;
    endfunction

    task automatic cycle(input bit v, input logic [127:0] d, input logic [3:0] sk,
                         input bit ce, input logic [3:0] cl, input bit fl);
        fetch_vld  = v;
        fetch_data = d;
        fetch_skip = sk;
        cons_en    = ce;
        cons_len   = cl;
        flush      = fl;
        @(posedge clk);
        #1;
        fetch_vld  = 1'b0;
        fetch_data = '0;
        fetch_skip = 4'd0;
        cons_en    = 1'b0;
        cons_len   = 4'd0;
        flush      = 1'b0;
    endtask

    int h;
    int t;
    int sent;
    int len;
    int occ_m;
    bit v;
    bit ce;
    int pat[3] = '{15, 15, 10};

    initial begin
        rst = 1'b1; flush = 1'b0; fetch_vld = 1'b0; fetch_data = '0;
        fetch_skip = 4'd0; cons_en = 1'b0; cons_len = 4'd0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        chk("rst_cnt", 128'(win_cnt), 128'd0);
        chk("rst_vld", 128'(win_vld), 128'd0);
        chk("rst_win", {win_hi, win_lo}, 128'd0);
        chk("rst_rdy", 128'(fetch_rdy), 128'd1);
        chk("rst_err", 128'(cons_err), 128'd0);

        // 1: first packet, no skip
        cycle(1'b1, mkpkt(8'h00), 4'd0, 1'b0, 4'd0, 1'b0);
        chk("t1_cnt", 128'(win_cnt), 128'd16);
        chk("t1_vld", 128'(win_vld), 128'd1);
        chk("t1_lo", 128'(win_lo), 128'h0706050403020100);
        chk("t1_hi", 128'(win_hi), 128'h0F0E0D0C0B0A0908);

        // 2: flush, skip on first packet only
        cycle(1'b0, '0, 4'd0, 1'b0, 4'd0, 1'b1);
        chk("t2_flush_cnt", 128'(win_cnt), 128'd0);
        chk("t2_flush_vld", 128'(win_vld), 128'd0);
        cycle(1'b1, mkpkt(8'h10), 4'd5, 1'b0, 4'd0, 1'b0);
        chk("t2_cnt", 128'(win_cnt), 128'd11);
        chk("t2_lo", 128'(win_lo), 128'h1C1B1A1918171615);
        chk("t2_hi", 128'(win_hi), 128'h00000000001F1E1D);
        chk("t2_vld", 128'(win_vld), 128'd0);
        cycle(1'b1, mkpkt(8'h20), 4'd7, 1'b0, 4'd0, 1'b0);
        chk("t2_cnt2", 128'(win_cnt), 128'd27);
        chk("t2_hi2", 128'(win_hi), 128'h24232221201F1E1D);

        // 3: fill to capacity, fetch_rdy threshold
        cycle(1'b0, '0, 4'd0, 1'b0, 4'd0, 1'b1);
        cycle(1'b1, mkpkt(8'h30), 4'd0, 1'b0, 4'd0, 1'b0);
        cycle(1'b1, mkpkt(8'h40), 4'd0, 1'b0, 4'd0, 1'b0);
        cycle(1'b1, mkpkt(8'h50), 4'd0, 1'b0, 4'd0, 1'b0);
        chk("t3_rdy48", 128'(fetch_rdy), 128'd1);
        cycle(1'b1, mkpkt(8'h60), 4'd0, 1'b0, 4'd0, 1'b0);
        chk("t3_cnt64", 128'(win_cnt), 128'd64);
        chk("t3_rdy64", 128'(fetch_rdy), 128'd0);
        chk("t3_lo64", 128'(win_lo), 128'h3736353433323130);
        cycle(1'b1, mkpkt(8'h99), 4'd0, 1'b1, 4'd3, 1'b0);
        chk("t3_cnt61", 128'(win_cnt), 128'd61);
        chk("t3_rdy61", 128'(fetch_rdy), 128'd0);
        chk("t3_wrap_lo", 128'(win_lo), 128'h3A39383736353433);
        chk("t3_wrap_hi", 128'(win_hi), 128'h4241403F3E3D3C3B);
        cycle(1'b0, '0, 4'd0, 1'b1, 4'd13, 1'b0);
        chk("t3_cnt48", 128'(win_cnt), 128'd48);
        chk("t3_rdy48b", 128'(fetch_rdy), 128'd1);
        chk("t3_lo48", 128'(win_lo), 128'h4746454443424140);

        // 4: simultaneous accept and consume at occ=20
        cycle(1'b0, '0, 4'd0, 1'b1, 4'd15, 1'b0);
        cycle(1'b0, '0, 4'd0, 1'b1, 4'd13, 1'b0);
        chk("t4_cnt20", 128'(win_cnt), 128'd20);
        cycle(1'b1, mkpkt(8'h70), 4'd0, 1'b1, 4'd9, 1'b0);
        chk("t4_cnt27", 128'(win_cnt), 128'd27);
        chk("t4_lo", 128'(win_lo), 128'h6C6B6A6968676665);
        chk("t4_hi", 128'(win_hi), 128'h74737271706F6E6D);

        // 5: streaming across ring wrap
        h = 8'h65;
        t = 8'h80;
        sent = 0;
        for (int it = 0; it < 80 && sent < 10; it++) begin
            occ_m = t - h;
            v = (occ_m <= 48);
            len = pat[it % 3];
            ce = (len <= occ_m);
            cycle(v, v ? mkpkt(t) : 128'd0, 4'd0, ce, 4'(len), 1'b0);
            if (v) begin
                t += 16;
                sent++;
            end
            if (ce) h += len;
            chk("t5_cnt", 128'(win_cnt), 128'(t - h));
            chk("t5_cap", 128'(win_cnt <= 7'd64), 128'd1);
            chk("t5_win", {win_hi, win_lo}, exp_win(h, t - h));
        end

        // 6: illegal consume, zero-length consume, flush priority
        for (int i = 0; i < 20 && (t - h) > 4; i++) begin
            len = ((t - h - 4) > 15) ? 15 : (t - h - 4);
            cycle(1'b0, '0, 4'd0, 1'b1, 4'(len), 1'b0);
            h += len;
        end
        chk("t6_cnt4", 128'(win_cnt), 128'd4);
        chk("t6_win4", {win_hi, win_lo}, exp_win(h, 4));
        cycle(1'b0, '0, 4'd0, 1'b1, 4'd6, 1'b0);
        chk("t6_err1", 128'(cons_err), 128'd1);
        chk("t6_cnt_kept", 128'(win_cnt), 128'd4);
        chk("t6_win_kept", {win_hi, win_lo}, exp_win(h, 4));
        cycle(1'b0, '0, 4'd0, 1'b0, 4'd0, 1'b0);
        chk("t6_err_pulse", 128'(cons_err), 128'd0);
        cycle(1'b0, '0, 4'd0, 1'b1, 4'd0, 1'b0);
        chk("t6_len0_err", 128'(cons_err), 128'd0);
        chk("t6_len0_cnt", 128'(win_cnt), 128'd4);
        cycle(1'b1, mkpkt(8'hC0), 4'd0, 1'b1, 4'd6, 1'b1);
        chk("t6_fl_cnt", 128'(win_cnt), 128'd0);
        chk("t6_fl_vld", 128'(win_vld), 128'd0);
        chk("t6_fl_rdy", 128'(fetch_rdy), 128'd1);
        chk("t6_fl_err", 128'(cons_err), 128'd0);
        chk("t6_fl_win", {win_hi, win_lo}, 128'd0);
        cycle(1'b1, mkpkt(8'hA0), 4'd3, 1'b0, 4'd0, 1'b0);
        chk("t6_skip_cnt", 128'(win_cnt), 128'd13);
        chk("t6_skip_win", {win_hi, win_lo}, exp_win(8'hA3, 13));

        // mid-stream reset
        cycle(1'b0, '0, 4'd0, 1'b1, 4'd14, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst2_cnt", 128'(win_cnt), 128'd0);
        chk("rst2_err", 128'(cons_err), 128'd0);
        chk("rst2_rdy", 128'(fetch_rdy), 128'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
